// File: rtl/dma_cmd_sequencer.sv
// Command front-end for the bus DMA engine: queues single-word read/write
// commands, stages data in the shared buffer word and sequences the DMA strobes.
module dma_cmd_sequencer #(
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [8:0] BUF_ADDR       = 9'h000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_read_n_write,
  input  logic [31:0]                   cmd_address,
  input  logic [3:0]                    cmd_byte_enable,
  input  logic [31:0]                   cmd_write_data,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_data,
  output logic                          rsp_timeout,
  output logic                          ipcore_dataReady,
  output logic                          ipcore_readReady,
  output logic [3:0]                    ipcore_byteEnable,
  output logic [31:0]                   ipcore_address_to_read,
  input  logic                          ipcore_switch_ready,
  output logic [8:0]                    bufferAddress,
  output logic [31:0]                   dataIn,
  output logic                          writeEnable,
  input  logic [31:0]                   dataOut,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_LAUNCH     = 3'd2;
  localparam logic [2:0] S_WAIT_START = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;
  localparam logic [2:0] S_RD_ADDR    = 3'd5;
  localparam logic [2:0] S_RD_DATA    = 3'd6;
  localparam logic [2:0] S_RESPOND    = 3'd7;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  cmd_t          head, cur;

  logic [2:0]  state, state_next;
  logic [15:0] to_cnt;
  logic        timeout_q;
  logic [31:0] rsp_q;
  logic        push, pop, timeout_hit, abort;

  assign cmd_ready   = (count != FULL_COUNT);
  assign push        = cmd_valid && cmd_ready;
  assign head        = fifo_mem[rd_ptr];
  assign timeout_hit = (to_cnt == TO_LAST);

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, so clearing them discards the contents.
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= '{rnw: cmd_read_n_write, addr: cmd_address,
                             be: cmd_byte_enable, data: cmd_write_data};
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0 && ipcore_switch_ready) begin
          pop        = 1'b1;
          state_next = head.rnw ? S_LAUNCH : S_LOAD;
        end
      end
      S_LOAD:   state_next = S_LAUNCH;
      S_LAUNCH: if (ipcore_switch_ready) state_next = S_WAIT_START;
      S_WAIT_START: begin
        if (!ipcore_switch_ready) begin
          state_next = S_WAIT_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = S_RESPOND;
        end
      end
      S_WAIT_DONE: begin
        // Completion wins over a timeout expiring in the same cycle.
        if (ipcore_switch_ready) begin
          state_next = cur.rnw ? S_RD_ADDR : S_RESPOND;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = S_RESPOND;
        end
      end
      S_RD_ADDR: state_next = S_RD_DATA;
      S_RD_DATA: state_next = S_RESPOND;
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur       <= '0;
      to_cnt    <= '0;
      timeout_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state <= state_next;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        cur       <= head;
        timeout_q <= 1'b0;
        rsp_q     <= '0;
      end

      if (state == S_LAUNCH && ipcore_switch_ready)
        to_cnt <= '0;
      else if (state == S_WAIT_START || state == S_WAIT_DONE)
        to_cnt <= to_cnt + 16'd1;

      if (abort)              timeout_q <= 1'b1;
      if (state == S_RD_DATA) rsp_q     <= dataOut;
    end
  end

  assign busy       = (state != S_IDLE);
  assign fifo_count = count;

  assign ipcore_address_to_read = busy ? cur.addr : '0;
  assign ipcore_byteEnable      = busy ? cur.be   : '0;
  assign ipcore_dataReady = (state == S_LAUNCH) && ipcore_switch_ready && !cur.rnw;
  assign ipcore_readReady = (state == S_LAUNCH) && ipcore_switch_ready &&  cur.rnw;

  assign bufferAddress = (state == S_LOAD || state == S_RD_ADDR) ? BUF_ADDR : '0;
  assign dataIn        = (state == S_LOAD) ? cur.data : '0;
  assign writeEnable   = (state == S_LOAD);

  assign rsp_valid   = (state == S_RESPOND);
  assign rsp_data    = rsp_valid ? rsp_q : '0;
  assign rsp_timeout = rsp_valid && timeout_q;

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer with a buffer model and a simple DMA
// model that can be driven by hand or run automatically.
module tb_dma_cmd_sequencer;

  logic        clock, reset;
  logic        cmd_valid, cmd_ready, cmd_read_n_write;
  logic [31:0] cmd_address, cmd_write_data;
  logic [3:0]  cmd_byte_enable;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_data;
  logic        ipcore_dataReady, ipcore_readReady, ipcore_switch_ready;
  logic [3:0]  ipcore_byteEnable;
  logic [31:0] ipcore_address_to_read;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn, dataOut;
  logic        writeEnable, busy;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  int dr_cnt = 0, rr_cnt = 0, rsp_cnt = 0, we_cnt = 0;

  logic        man_sr, dma_auto, dma_we;
  logic        auto_sr = 1'b1;
  logic [2:0]  auto_cnt = 3'd0;
  logic [31:0] dma_wdata;
  logic [31:0] buf_mem [512];

  dma_cmd_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read_n_write(cmd_read_n_write), .cmd_address(cmd_address),
    .cmd_byte_enable(cmd_byte_enable), .cmd_write_data(cmd_write_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .ipcore_dataReady(ipcore_dataReady), .ipcore_readReady(ipcore_readReady),
    .ipcore_byteEnable(ipcore_byteEnable),
    .ipcore_address_to_read(ipcore_address_to_read),
    .ipcore_switch_ready(ipcore_switch_ready),
    .bufferAddress(bufferAddress), .dataIn(dataIn), .writeEnable(writeEnable),
    .dataOut(dataOut), .busy(busy), .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ipcore_switch_ready = dma_auto ? auto_sr : man_sr;

  // Auto DMA: on a strobe go busy, answer reads with ~address, idle again 3 cycles later.
  always @(posedge clock) begin
    if (!dma_auto) begin
      auto_sr  <= 1'b1;
      auto_cnt <= 3'd0;
    end else if (ipcore_dataReady || ipcore_readReady) begin
      auto_sr  <= 1'b0;
      auto_cnt <= 3'd3;
    end else if (auto_cnt != 3'd0) begin
      auto_cnt <= auto_cnt - 3'd1;
      if (auto_cnt == 3'd1) auto_sr <= 1'b1;
    end
  end

  always @(posedge clock) begin
    if (writeEnable)                         buf_mem[bufferAddress] <= dataIn;
    else if (dma_auto && ipcore_readReady)   buf_mem[9'h000] <= ~ipcore_address_to_read;
    else if (dma_we)                         buf_mem[9'h000] <= dma_wdata;
    dataOut <= buf_mem[bufferAddress];
  end

  always @(posedge clock) begin
    if (ipcore_dataReady) dr_cnt++;
    if (ipcore_readReady) rr_cnt++;
    if (rsp_valid)        rsp_cnt++;
    if (writeEnable)      we_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!(ipcore_dataReady || ipcore_readReady) && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(ipcore_dataReady || ipcore_readReady), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < bound);
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic push_cmd(input logic rnw, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
    cmd_read_n_write = rnw;
    cmd_address      = addr;
    cmd_byte_enable  = be;
    cmd_write_data   = data;
    cmd_valid        = 1'b1;
    tick();
    cmd_valid        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, dr0, rr0, rsp0, we0;
    logic [31:0] addrs [5];

    reset = 1'b0; cmd_valid = 1'b0; cmd_read_n_write = 1'b0;
    cmd_address = '0; cmd_byte_enable = '0; cmd_write_data = '0;
    man_sr = 1'b1; dma_auto = 1'b0; dma_we = 1'b0; dma_wdata = '0;

    // Reset state
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_count",     32'(fifo_count), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_we",        32'(writeEnable), 32'd0);
    check("rst_addr",      ipcore_address_to_read, 32'd0);
    #10 reset = 1'b1;
    tick();

    // Write command
    we0 = we_cnt; dr0 = dr_cnt;
    push_cmd(1'b0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF);
    check("wr_count_after_push", 32'(fifo_count), 32'd1);
    tick();
    check("wr_load_we",    32'(writeEnable), 32'd1);
    check("wr_load_data",  dataIn, 32'hDEAD_BEEF);
    check("wr_load_baddr", 32'(bufferAddress), 32'h000);
    check("wr_load_nostb", 32'(ipcore_dataReady), 32'd0);
    check("wr_addr",       ipcore_address_to_read, 32'h4000_0010);
    check("wr_be",         32'(ipcore_byteEnable), 32'hF);
    check("wr_count_pop",  32'(fifo_count), 32'd0);
    tick();
    check("wr_strobe",     32'(ipcore_dataReady), 32'd1);
    check("wr_buf_word",   buf_mem[0], 32'hDEAD_BEEF);
    tick();
    man_sr = 1'b0;
    #1;
    check("wr_strobe_gone", 32'(ipcore_dataReady), 32'd0);
    repeat (6) tick();
    man_sr = 1'b1;
    wait_rsp("wr_rsp", 20, n);
    check("wr_rsp_data",  rsp_data, 32'd0);
    check("wr_rsp_to",    32'(rsp_timeout), 32'd0);
    check("wr_strobes",   32'(dr_cnt - dr0), 32'd1);
    check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    tick();

    // Read command, response 3 cycles after switch_ready rises
    rr0 = rr_cnt;
    push_cmd(1'b1, 32'h4000_0020, 4'h3, 32'h0);
    wait_strobe("rd_strobe");
    check("rd_addr", ipcore_address_to_read, 32'h4000_0020);
    check("rd_be",   32'(ipcore_byteEnable), 32'h3);
    tick();
    man_sr = 1'b0;
    repeat (3) tick();
    dma_wdata = 32'h1234_5678; dma_we = 1'b1;
    tick();
    dma_we = 1'b0;
    man_sr = 1'b1;
    wait_rsp("rd_rsp", 10, n);
    check("rd_latency",  32'(n), 32'd3);
    check("rd_rsp_data", rsp_data, 32'h1234_5678);
    check("rd_rsp_to",   32'(rsp_timeout), 32'd0);
    check("rd_strobes",  32'(rr_cnt - rr0), 32'd1);
    tick();

    // FIFO full with DMA busy, then drain in order
    man_sr = 1'b0;
    for (int i = 0; i < 5; i++) addrs[i] = 32'h4000_0100 + 32'(i * 4);
    cmd_read_n_write = 1'b1; cmd_byte_enable = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_address = addrs[i];
      #1;
      check("full_ready_before", 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_address = addrs[4];
    check("full_count",  32'(fifo_count), 32'd4);
    check("full_ready",  32'(cmd_ready), 32'd0);
    tick();
    check("full_hold",   32'(fifo_count), 32'd4);
    dma_auto = 1'b1;
    tick();
    check("full_pop_count", 32'(fifo_count), 32'd3);
    check("full_pop_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("full_fifth_in", 32'(fifo_count), 32'd4);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("order_rsp", 60, n);
      check("order_data", rsp_data, ~addrs[i]);
    end
    tick();
    dma_auto = 1'b0; man_sr = 1'b1;
    tick();

    // Timeout on a read whose DMA never leaves idle
    push_cmd(1'b1, 32'h4000_0030, 4'hF, 32'h0);
    wait_strobe("to_strobe");
    wait_rsp("to_rsp", 1100, n);
    check("to_cycles",   32'(n), 32'd1025);
    check("to_flag",     32'(rsp_timeout), 32'd1);
    check("to_rsp_data", rsp_data, 32'd0);
    tick();
    dma_auto = 1'b1; dr0 = dr_cnt;
    push_cmd(1'b0, 32'h4000_0040, 4'hF, 32'hA5A5_5A5A);
    wait_rsp("after_to_rsp", 60, n);
    check("after_to_flag",   32'(rsp_timeout), 32'd0);
    check("after_to_strobe", 32'(dr_cnt - dr0), 32'd1);
    tick();
    dma_auto = 1'b0; man_sr = 1'b1;
    tick();

    // switch_ready low on LAUNCH entry holds the strobe off
    push_cmd(1'b0, 32'h4000_0050, 4'hF, 32'h0000_0050);
    tick();
    check("hold_load", 32'(writeEnable), 32'd1);
    man_sr = 1'b0; dr0 = dr_cnt;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_nostrobe", 32'(ipcore_dataReady), 32'd0);
      check("hold_busy",     32'(busy), 32'd1);
      if (i < 2) tick();
    end
    tick();
    man_sr = 1'b1;
    #1;
    check("hold_strobe", 32'(ipcore_dataReady), 32'd1);
    tick();
    check("hold_strobe_end", 32'(ipcore_dataReady), 32'd0);
    man_sr = 1'b0;
    repeat (2) tick();
    man_sr = 1'b1;
    wait_rsp("hold_rsp", 20, n);
    check("hold_strobe_count", 32'(dr_cnt - dr0), 32'd1);
    tick();

    // Reset during WAIT_DONE with two commands queued
    cmd_read_n_write = 1'b0; cmd_byte_enable = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_address = 32'h4000_0200 + 32'(i * 4);
      cmd_write_data = 32'(i);
      tick();
    end
    cmd_valid = 1'b0;
    check("rstmid_strobe", 32'(ipcore_dataReady), 32'd1);
    tick();
    man_sr = 1'b0;
    repeat (2) tick();
    check("rstmid_queued", 32'(fifo_count), 32'd2);
    check("rstmid_busy",   32'(busy), 32'd1);
    rsp0 = rsp_cnt;
    #2 reset = 1'b0;
    #1;
    check("rstmid_count",  32'(fifo_count), 32'd0);
    check("rstmid_idle",   32'(busy), 32'd0);
    check("rstmid_ready",  32'(cmd_ready), 32'd1);
    check("rstmid_addr",   ipcore_address_to_read, 32'd0);
    check("rstmid_be",     32'(ipcore_byteEnable), 32'd0);
    check("rstmid_baddr",  32'(bufferAddress), 32'd0);
    check("rstmid_din",    dataIn, 32'd0);
    check("rstmid_strobes", 32'({ipcore_dataReady, ipcore_readReady, writeEnable}), 32'd0);
    check("rstmid_rsp",    32'({rsp_valid, rsp_timeout}), 32'd0);
    check("rstmid_rdata",  rsp_data, 32'd0);
    #3;
    man_sr = 1'b1;
    reset  = 1'b1;
    repeat (20) tick();
    check("rstmid_no_rsp",     32'(rsp_cnt - rsp0), 32'd0);
    check("rstmid_count_post", 32'(fifo_count), 32'd0);
    check("rstmid_idle_post",  32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_cmd_sequencer.md
Name: dma_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of the bus DMA engine on the JTAG side.
- Accepts decoded single-word read/write commands into a small FIFO and stages write data in the shared single-word transfer buffer.
- Fires the DMA's dataReady/readReady strobes and tracks completion via ipcore_switch_ready.
- For reads, fetches the returned word from the buffer and emits one response per command.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, minimum 2.
- BUF_ADDR, 9'h000: buffer word used for transfers; must match the DMA's fixed buffer location.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT_START+WAIT_DONE before abort; range 2..65535.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_read_n_write  in  1  1=read, 0=write
- cmd_address  in  32  bus byte address
- cmd_byte_enable  in  4  lane enables
- cmd_write_data  in  32  write payload (ignored for reads)
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  32  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: command aborted
- ipcore_dataReady  out  1  write launch strobe to DMA
- ipcore_readReady  out  1  read launch strobe to DMA
- ipcore_byteEnable  out  4  latched byte enable
- ipcore_address_to_read  out  32  latched address
- ipcore_switch_ready  in  1  DMA idle/end-of-transaction indicator
- bufferAddress  out  9  buffer port address
- dataIn  out  32  buffer write data
- writeEnable  out  1  buffer write strobe
- dataOut  in  32  buffer read data, 1-cycle synchronous latency
- busy  out  1  state != IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, all outputs 0 except cmd_ready=1; timeout counter 0.
- Reset mid-operation: abort immediately; FIFO contents discarded; no response.
- FIFO push when cmd_valid&&cmd_ready. cmd_ready=(count!=FIFO_DEPTH), from registered count, no same-cycle bypass when full. Simultaneous push+pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- IDLE: if FIFO non-empty and ipcore_switch_ready=1, pop the head into cur_* registers. Next state: LOAD for writes, LAUNCH for reads.
- LOAD (1 cycle): bufferAddress=BUF_ADDR, dataIn=cur_data, writeEnable=1. -> LAUNCH.
- LAUNCH: if ipcore_switch_ready=1, assert ipcore_dataReady (write) or ipcore_readReady (read) for exactly this cycle, clear the timeout counter, -> WAIT_START. Otherwise hold in LAUNCH with no strobe.
- WAIT_START: wait for ipcore_switch_ready=0 (DMA left idle). -> WAIT_DONE.
- WAIT_DONE: wait for ipcore_switch_ready=1. Then -> RESPOND for writes, -> RD_ADDR for reads.
- Timeout: counter increments each cycle in WAIT_START/WAIT_DONE. When count==TIMEOUT_CYCLES-1, -> RESPOND with timeout flag set and rsp_data=0; a read aborted this way skips RD_ADDR/RD_DATA.
- RD_ADDR: bufferAddress=BUF_ADDR, writeEnable=0. -> RD_DATA.
- RD_DATA: capture dataOut into the response register. -> RESPOND.
- RESPOND (1 cycle): rsp_valid=1; rsp_data and rsp_timeout valid; no backpressure. -> IDLE.
- Outputs outside their states:
  - ipcore_address_to_read/ipcore_byteEnable: hold cur_* from LOAD through RESPOND; 0 in IDLE.
  - bufferAddress/dataIn/writeEnable: 0 outside LOAD/RD_ADDR.
  - rsp_data/rsp_timeout: 0 outside RESPOND.
- Minimum latency, pop to rsp_valid, with DMA responding promptly:
  - write: IDLE, LOAD, LAUNCH, WAIT_START, WAIT_DONE..., RESPOND.
  - read: adds RD_ADDR and RD_DATA.
- A DMA bus error returns the DMA to idle and raises switch_ready. This completes the command normally; no error is reported (data undefined).
- Commands execute strictly in FIFO order; exactly one response per accepted command.

Test Plan:
- Write 0x40000010/BE=4'hF/data 0xDEADBEEF, DMA model going not-ready 1 cycle after strobe and ready 6 cycles later -> writeEnable pulse with dataIn=0xDEADBEEF at BUF_ADDR before the single ipcore_dataReady pulse; one rsp_valid with rsp_data=0, rsp_timeout=0.
- Read 0x40000020/BE=4'h3, DMA model writes 0x12345678 into the buffer before raising switch_ready -> single ipcore_readReady pulse, ipcore_address_to_read=0x40000020; rsp_valid with rsp_data=0x12345678 exactly 3 cycles after switch_ready rises.
- Push 5 back-to-back commands with the DMA held busy (switch_ready=0) -> cmd_ready drops after 4th accept, fifo_count=4, 5th accepted only after first pop; responses in push order.
- Launch a read; DMA never drops switch_ready -> rsp_valid with rsp_timeout=1, rsp_data=0 after TIMEOUT_CYCLES cycles; next command launches normally.
- Assert reset low in WAIT_DONE with 2 queued commands -> all outputs 0 asynchronously, fifo_count=0, no rsp_valid after release.
- switch_ready=0 at LAUNCH entry for 3 cycles -> no strobe until it returns to 1, then exactly one strobe.
